serial_compare_ctrl: RTL and testbench
======================================

Name: serial_compare_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands by stepping a single shared 2-bit equality comparator (comparator_2bit style: a, b in; aeqb out) across the operands, MSB pair first.
- Stops at the first unequal pair and reports equal / greater / less.
- Sits between a requesting datapath (start/done handshake) and the shared comparator instance. The comparator stays combinational and outside this block.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2. NDIG = WIDTH/2 digit pairs.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a compare. Sampled only in IDLE or DONE.
- abort  in  1  cancel an in-progress compare.
- a  in  WIDTH  operand A, captured when start is accepted.
- b  in  WIDTH  operand B, captured when start is accepted.
- cmp_a  out  2  digit of latched A driven to the shared comparator.
- cmp_b  out  2  digit of latched B driven to the shared comparator.
- cmp_eq  in  1  comparator equality result for cmp_a/cmp_b, same cycle.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse; results valid from this cycle.
- aeqb  out  1  result: A == B.
- agtb  out  1  result: A > B.
- altb  out  1  result: A < B.
- steps  out  clog2(NDIG)+1  number of digit compares used by the last completed operation.

Behaviour:
- Reset (asynchronous, any state):
  - State = IDLE.
  - busy, done, aeqb, agtb, altb = 0; steps = 0.
  - Operand registers and digit index = 0; cmp_a = cmp_b = 0.
- States: IDLE, SCAN, DONE. Encoding is free.
- IDLE: start = 1 latches a and b, sets idx = NDIG-1, and moves to SCAN. Result outputs are unchanged.
- SCAN:
  - busy = 1.
  - cmp_a = A_reg[2*idx+1 : 2*idx]; cmp_b = B_reg[2*idx+1 : 2*idx]. Both are combinational from registers.
  - If abort = 1: go to IDLE. No done pulse. Results are unchanged. abort has priority over every other SCAN condition.
  - Else if cmp_eq = 0: register agtb = (cmp_a > cmp_b) as a 2-bit unsigned compare done inside this block, altb = !agtb, aeqb = 0. Go to DONE.
  - Else if idx = 0: register aeqb = 1, agtb = altb = 0. Go to DONE.
  - Else: idx = idx - 1 and stay in SCAN.
  - Every SCAN cycle increments an internal step counter. steps is loaded from that counter on exit to DONE.
- DONE:
  - done = 1 for exactly this one cycle; busy = 0.
  - Results hold until the next DONE. They are not cleared by start.
  - start = 1 here is accepted exactly as in IDLE (operands latched, next state SCAN). Otherwise go to IDLE.
- Exactly one of aeqb, agtb, altb is high after the first completed compare. All three are 0 only before the first completion after reset.
- start while busy: ignored, not queued. a and b changing during SCAN do not affect the operation.
- abort in IDLE or DONE: ignored.
- Latency: start accepted at edge E. SCAN occupies k cycles, where k = 1 + index from the MSB of the first unequal digit, or NDIG if the operands are equal. done is high in cycle E + k + 1.
  - Best case: done 2 cycles after start.
  - Worst case: done NDIG + 1 cycles after start.
- Back-to-back: a start held high continuously gives one compare every k + 1 cycles.
- cmp_eq is trusted as given. The block does not recheck equality.
- Reset asserted mid-SCAN: immediate return to IDLE with all outputs cleared. No done.

Test Plan:
- Reset, then WIDTH = 8, a = 8'hA5, b = 8'hA5, start for 1 cycle -> busy high for 4 cycles, done 5 cycles after start, aeqb = 1, agtb = altb = 0, steps = 4.
- a = 8'hC0, b = 8'h40 -> mismatch on the first digit (3 vs 1), done 2 cycles after start, agtb = 1, steps = 1, cmp_a/cmp_b observed = 2'b11/2'b01.
- a = 8'h12, b = 8'h13 -> mismatch on the last digit, altb = 1, steps = 4. Holding start high through DONE with new operands 8'hFF/8'h00 -> second compare begins with no IDLE cycle, agtb = 1, steps = 1.
- Start a = 8'h00, b = 8'h03, assert abort in the 2nd SCAN cycle -> IDLE next cycle, no done, previous results unchanged. start pulsed during SCAN of another compare -> ignored.
- Assert reset during SCAN -> all outputs 0 immediately (asynchronous, before the next clock edge), no done. The next start completes normally.
- Feed a deliberately faulty cmp_eq stuck at 1 with a = 8'h01, b = 8'h00 -> aeqb = 1 after 4 steps, confirming cmp_eq is trusted as given.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
// Serial magnitude compare of two WIDTH-bit operands, MSB digit pair first,
// using an external shared 2-bit equality comparator.
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  output logic [1:0]                    cmp_a,
  output logic [1:0]                    cmp_b,
  input  logic                          cmp_eq,
  output logic                          busy,
  output logic                          done,
  output logic                          aeqb,
  output logic                          agtb,
  output logic                          altb,
  output logic [$clog2(WIDTH/2):0]      steps
);

  localparam int NDIG = WIDTH / 2;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW   = $clog2(NDIG) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             accept;

  assign cmp_a = a_q[{idx_q, 1'b0} +: 2];
  assign cmp_b = b_q[{idx_q, 1'b0} +: 2];
  assign busy  = (state_q == S_SCAN);
  assign done  = (state_q == S_DONE);
  assign aeqb  = eq_q;
  assign agtb  = gt_q;
  assign altb  = lt_q;
  assign steps = steps_q;

  assign accept = start &&
    (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IW'(NDIG - 1);
          cnt_d   = '0;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        // abort outranks any result this cycle would produce
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + SW'(1);
          if (!cmp_eq) begin
            eq_d    = 1'b0;
            gt_d    = (cmp_a > cmp_b);
            lt_d    = !(cmp_a > cmp_b);
            steps_d = cnt_q + SW'(1);
            state_d = S_DONE;
          end else if (idx_q == '0) begin
            eq_d    = 1'b1;
            gt_d    = 1'b0;
            lt_d    = 1'b0;
            steps_d = cnt_q + SW'(1);
            state_d = S_DONE;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      steps_q <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl: driver pushes model results,
// monitor pops and compares on every done pulse.
module tb_serial_compare_ctrl;

  localparam int WIDTH = 8;
  localparam int NDIG  = WIDTH / 2;

  typedef struct {
    logic eq;
    logic gt;
    logic lt;
    int   steps;
    int   due;
  } exp_t;

  logic             clk = 0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       cmp_a;
  logic [1:0]       cmp_b;
  logic             cmp_eq;
  logic             busy;
  logic             done;
  logic             aeqb;
  logic             agtb;
  logic             altb;
  logic [$clog2(NDIG):0] steps;

  bit   stuck = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t last;

  assign cmp_eq = stuck | (cmp_a == cmp_b);

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .a(a), .b(b), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq),
    .busy(busy), .done(done), .aeqb(aeqb), .agtb(agtb),
    .altb(altb), .steps(steps)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input longint act,
                     input longint ex);
    checks++;
    if (act != ex) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               n, act, ex, cyc);
    end
  endtask

  // Reference: first differing digit from the MSB decides; an always-equal
  // comparator makes every compare look equal after all digits.
  function automatic exp_t model(logic [WIDTH-1:0] x,
                                 logic [WIDTH-1:0] y,
                                 bit st, int c);
    exp_t e;
    e.eq = 1; e.gt = 0; e.lt = 0; e.steps = NDIG;
    if (!st && x != y) begin
      e.eq = 0;
      e.gt = (x > y);
      e.lt = (x < y);
      for (int i = NDIG - 1; i >= 0; i--)
        if (x[2*i+:2] != y[2*i+:2]) begin
          e.steps = NDIG - i;
          break;
        end
    end
    e.due = c + e.steps + 1;
    return e;
  endfunction

  // monitor
  initial begin
    last = '{0, 0, 0, 0, 0};
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("done_timeout", 0, 1);
        void'(sb.pop_front());
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc, e.due);
          chk("aeqb", aeqb, e.eq);
          chk("agtb", agtb, e.gt);
          chk("altb", altb, e.lt);
          chk("steps", steps, e.steps);
          chk("busy_in_done", busy, 0);
          last = e;
        end
      end
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y);
    exp_t e;
    @(negedge clk);
    a = x; b = y; start = 1;
    e = model(x, y, stuck, cyc);
    sb.push_back(e);
    @(negedge clk);
    start = 0;
    chk("busy_scan", busy, 1);
    chk("cmp_a_msb", cmp_a, x[WIDTH-1-:2]);
    chk("cmp_b_msb", cmp_b, y[WIDTH-1-:2]);
    repeat (e.steps) @(negedge clk);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_res"}, {aeqb, agtb, altb}, 0);
    chk({n, "_steps"}, steps, 0);
    chk({n, "_cmp"}, {cmp_a, cmp_b}, 0);
  endtask

  initial begin
    exp_t e;
    logic [WIDTH-1:0] x, y;
    reset = 1; start = 0; abort = 0; a = 0; b = 0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 0;

    run_op(8'hA5, 8'hA5);
    run_op(8'hC0, 8'h40);

    // start held through DONE: second compare follows with no IDLE gap
    @(negedge clk);
    a = 8'h12; b = 8'h13; start = 1;
    sb.push_back(model(8'h12, 8'h13, 0, cyc));
    repeat (5) @(negedge clk);
    chk("b2b_done", done, 1);
    a = 8'hFF; b = 8'h00;
    sb.push_back(model(8'hFF, 8'h00, 0, cyc));
    @(negedge clk);
    start = 0;
    chk("b2b_busy", busy, 1);
    repeat (2) @(negedge clk);

    // abort in the 2nd SCAN cycle
    a = 8'h00; b = 8'h03; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", {aeqb, agtb, altb}, {last.eq, last.gt, last.lt});
    chk("abort_steps", steps, last.steps);

    // start during SCAN is ignored
    @(negedge clk);
    a = 8'h00; b = 8'h01; start = 1;
    sb.push_back(model(8'h00, 8'h01, 0, cyc));
    @(negedge clk);
    start = 0;
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);

    repeat (40) begin
      x = WIDTH'($urandom);
      y = x;
      if ($urandom_range(0, 3) != 0)
        y = x ^ WIDTH'($urandom_range(1, 3) << (2 * $urandom_range(0, NDIG - 1)));
      run_op(x, y);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // asynchronous reset mid-SCAN
    @(negedge clk);
    a = 8'h55; b = 8'h56; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    reset = 1;
    #1;
    chk_zero("async_reset");
    sb.delete();
    @(negedge clk);
    reset = 0;
    run_op(8'h3C, 8'h3C);
    run_op(8'h80, 8'h81);

    stuck = 1;
    run_op(8'h01, 8'h00);
    stuck = 0;

    repeat (6) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
